// File: rtl/ram_pkg.sv
// Shared types and the byte-lane merge helper for the simple-dual-port RAM.
package ram_pkg;

  typedef enum {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;
  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_e;

  // Widest word be_merge can handle; callers zero-extend into it and cast the result back.
  localparam int MAX_W = 1024;

  function automatic logic [MAX_W-1:0] be_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] be,
    input int               byte_w
  );
    logic [MAX_W-1:0] m;
    for (int i = 0; i < MAX_W; i++)
      m[10'(i)] = be[10'(i / byte_w)] ? new_w[10'(i)] : old_w[10'(i)];
    return m;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: sweeps every address once, one word per cycle, on reset or on request.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;

  // A request arriving mid-sweep is dropped; only reset restarts a sweep.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLR_SWEEP : CLR_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          if (i_clr) r_state <= CLR_SWEEP;
        end
        CLR_SWEEP: begin
          if (r_cnt == LAST) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_busy     = (r_state == CLR_SWEEP);
  assign o_clr_we   = (r_state == CLR_SWEEP);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_sp_be_sync.sv
// Simple-dual-port byte-enable RAM with selectable read latency, read-during-write mode
// and a built-in clear sweep that owns the write port while active.
module ram_sp_be_sync
  import ram_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 256,
  parameter int               BYTE_W         = 8,
  parameter int               RD_LATENCY     = 1,
  parameter int               RDW_MODE       = 0,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL      = '0,
  parameter int               ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  output logic                    o_busy,
  input  logic                    i_wr_en,
  input  logic [WIDTH/BYTE_W-1:0] i_wr_be,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd_en,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic                    o_rd_dv
);

  localparam int NB = WIDTH / BYTE_W;
  localparam bit WF = (RDW_MODE == RDW_WRITE_FIRST);

  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("ram_sp_be_sync: WIDTH must be a multiple of BYTE_W");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("ram_sp_be_sync: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("ram_sp_be_sync: RDW_MODE must be 0 or 1");
  end
  if (WIDTH > MAX_W) begin : g_bad_max
    $error("ram_sp_be_sync: WIDTH exceeds ram_pkg::MAX_W");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  ram_clear_ctrl #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_clr),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign o_busy = w_busy;

  logic w_wr_in_range;
  logic w_rd_in_range;
  logic w_user_we;
  logic w_rd_acc;

  assign w_wr_in_range = (32'(i_wr_addr) < DEPTH);
  assign w_rd_in_range = (32'(i_rd_addr) < DEPTH);
  assign w_user_we     = i_wr_en & ~w_busy & w_wr_in_range;
  assign w_rd_acc      = i_rd_en & ~w_busy;

  // Write port mux: the sweep takes the port whole-word; user traffic is shut out meanwhile.
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic [NB-1:0]     w_be;

  always_comb begin
    w_we   = 1'b0;
    w_addr = i_wr_addr;
    w_data = i_wr_data;
    w_be   = i_wr_be;
    if (i_rst_n) begin
      if (w_busy) begin
        w_we   = w_clr_we;
        w_addr = w_clr_addr;
        w_data = CLEAR_VAL;
        w_be   = '1;
      end else begin
        w_we = w_user_we;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int k = 0; k < NB; k++)
        if (w_be[k]) r_mem[w_addr][k*BYTE_W +: BYTE_W] <= w_data[k*BYTE_W +: BYTE_W];
    end
  end

  // Read word with optional same-address bypass of the concurrent user write.
  logic [WIDTH-1:0] w_rd_old;
  logic [WIDTH-1:0] w_rd_merged;
  logic [WIDTH-1:0] w_rd_word;

  assign w_rd_old    = w_rd_in_range ? r_mem[i_rd_addr] : '0;
  assign w_rd_merged = WIDTH'(be_merge(MAX_W'(w_rd_old), MAX_W'(i_wr_data),
                                       MAX_W'(i_wr_be), BYTE_W));

  always_comb begin
    w_rd_word = w_rd_old;
    if (!w_rd_in_range)
      w_rd_word = '0;
    else if (WF && w_user_we && (i_wr_addr == i_rd_addr))
      w_rd_word = w_rd_merged;
  end

  // Valid shift register plus data stages; each data stage only loads on valid so
  // the output holds its last value between results.
  logic [RD_LATENCY:1] r_vld_pipe;
  logic [WIDTH-1:0]    r_dat_pipe [RD_LATENCY:1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      for (int k = 1; k <= RD_LATENCY; k++) r_dat_pipe[k] <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd_acc;
      if (w_rd_acc) r_dat_pipe[1] <= w_rd_word;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  assign o_rd_dv   = r_vld_pipe[RD_LATENCY];
  assign o_rd_data = r_dat_pipe[RD_LATENCY];

endmodule

// File: tb/tb_ram_sp_be_sync.sv
// Two RAM configurations driven by shared directed stimulus, checked each cycle against a
// behavioural model and at key points against hand-computed literals.
module tb_ram_sp_be_sync;

  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_be = '0, wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy_a, dv_a, busy_b, dv_b;
  logic [31:0] rd_a, rd_b;

  always #5 clk = ~clk;

  // A: DEPTH 16, latency 1, read-first.  B: DEPTH 12, latency 2, write-first.
  ram_sp_be_sync #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0),
                   .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_busy(busy_a),
    .i_wr_en(wr_en), .i_wr_be(wr_be), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_a), .o_rd_dv(dv_a));

  ram_sp_be_sync #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1),
                   .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_busy(busy_b),
    .i_wr_en(wr_en), .i_wr_be(wr_be), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_b), .o_rd_dv(dv_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          dep [2] = '{16, 12};
  int          lat [2] = '{1, 2};
  bit          wf  [2] = '{1'b0, 1'b1};
  logic [31:0] mem [2][16];
  int          rem [2];            // sweep cycles still to run
  bit          sv  [2][4];         // scheduled results, indexed by cycle mod 4
  logic [31:0] sd  [2][4];
  logic [31:0] e_data [2];
  bit          e_dv [2];
  bit          e_busy [2];
  longint      cyc = 0;
  bit          armed = 1'b0;
  int          m_slot;
  bit          m_bz;
  logic [31:0] m_rv;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_slot = int'(cyc % 4);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        rem[d] = dep[d];
        for (int s = 0; s < 4; s++) sv[d][s] = 1'b0;
        e_dv[d]   = 1'b0;
        e_data[d] = '0;
        armed     = 1'b1;
      end else begin
        m_bz = (rem[d] > 0);
        if (m_bz) begin
          mem[d][dep[d] - rem[d]] = CV;
          rem[d]--;
        end else if (clr) begin
          rem[d] = dep[d];
        end
        if (rd_en && !m_bz) begin
          if (int'(rd_addr) >= dep[d]) m_rv = '0;
          else if (wf[d] && wr_en && wr_addr == rd_addr && int'(wr_addr) < dep[d])
            m_rv = merge(mem[d][rd_addr], wr_data, wr_be);
          else m_rv = mem[d][rd_addr];
          sv[d][(m_slot + lat[d] - 1) % 4] = 1'b1;
          sd[d][(m_slot + lat[d] - 1) % 4] = m_rv;
        end
        if (wr_en && !m_bz && int'(wr_addr) < dep[d])
          mem[d][wr_addr] = merge(mem[d][wr_addr], wr_data, wr_be);
        e_dv[d] = sv[d][m_slot];
        if (sv[d][m_slot]) e_data[d] = sd[d][m_slot];
        sv[d][m_slot] = 1'b0;
      end
      e_busy[d] = (rem[d] > 0);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy_a", busy_a, e_busy[0]);
      chk("dv_a",   dv_a,   e_dv[0]);
      chk("data_a", rd_a,   e_data[0]);
      chk("busy_b", busy_b, e_busy[1]);
      chk("dv_b",   dv_b,   e_dv[1]);
      chk("data_b", rd_b,   e_data[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] d4(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  int na, nb, n;

  initial begin
    step(); step();
    chk("rst_dv_a", dv_a, 0);
    chk("rst_data_a", rd_a, 0);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_data_b", rd_b, 0);

    // test 1: sweep after reset, then every address reads the clear value
    rst_n = 1'b1;
    na = 0; nb = 0; n = 0;
    while ((busy_a || busy_b) && n < 100) begin
      na += int'(busy_a); nb += int'(busy_b); n++; step();
    end
    chk("busy_len_a", na, 16);
    chk("busy_len_b", nb, 12);
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a); step();
      chk("t1_dv_a", dv_a, 1);
      chk("t1_data_a", rd_a, CV);
    end
    rd_en = 1'b0; step(); step();

    // test 2: byte-enable merge and read latency
    wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'b1111; wr_data = 32'h11223344; step();
    wr_be = 4'b0101; wr_data = 32'hFFFFFFFF; step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3; step();
    rd_en = 1'b0;
    chk("t2_dv_a", dv_a, 1);
    chk("t2_data_a", rd_a, 32'h11FF33FF);
    chk("t2_dv_b_early", dv_b, 0);
    step();
    chk("t2_dv_b", dv_b, 1);
    chk("t2_data_b", rd_b, 32'h11FF33FF);
    chk("t2_dv_a_end", dv_a, 0);
    step();

    // test 3: same-address read during write
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b1111; wr_data = 32'h0; step();
    wr_be = 4'b1100; wr_data = 32'hDEADBEEF; rd_en = 1'b1; rd_addr = 4'd5; step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t3_rf_a", rd_a, 32'h00000000);
    step();
    chk("t3_wf_b", rd_b, 32'hDEAD0000);
    step();

    // test 4: streaming reads with no bubbles
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_be = 4'b1111; wr_addr = 4'(a); wr_data = d4(a); step();
    end
    wr_en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a); step();
      chk("t4_dv_a", dv_a, 1);
      chk("t4_data_a", rd_a, d4(a));
    end
    rd_en = 1'b0; step();
    chk("t4_end_dv_a", dv_a, 0);
    chk("t4_last_b", rd_b, d4(7));
    step();

    // test 5: out-of-range access on the 12-deep instance
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h55; wr_be = 4'b1111; step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd13; step();
    chk("t5_data_a", rd_a, 32'h55);
    rd_addr = 4'd1; step();
    rd_en = 1'b0;
    chk("t5_dv_b", dv_b, 1);
    chk("t5_data_b", rd_b, 32'h0);
    step();
    chk("t5_addr1_b", rd_b, d4(1));
    step();

    // test 6: sweep request, reset mid-sweep, ignored clr and ignored traffic
    clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd2; step();
    clr = 1'b0; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h77; wr_be = 4'b1111;
    chk("t6_inflight_a", rd_a, d4(2));
    step();
    chk("t6_busy_a", busy_a, 1);
    chk("t6_busy_dv_a", dv_a, 0);
    step();
    clr = 1'b1; step();
    clr = 1'b0; step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    na = 0; nb = 0; n = 0;
    while ((busy_a || busy_b) && n < 100) begin
      na += int'(busy_a); nb += int'(busy_b);
      clr = (n == 6); rd_en = busy_b; wr_en = busy_b;
      n++; step();
    end
    clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    chk("t6_len_a", na, 16);
    chk("t6_len_b", nb, 12);
    rd_en = 1'b1; rd_addr = 4'd2; step();
    rd_en = 1'b0;
    chk("t6_addr2_a", rd_a, CV);
    step();
    chk("t6_addr2_b", rd_b, CV);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
